// File: rtl/keypad_scanner_pkg.sv
// Shared constants, DataOut bit map and debounce state encoding for the keypad scanner.
// No logic here; the key priority encoder is a pure combinational helper.
package keypad_scanner_pkg;

    localparam int NCOL                = 4;
    localparam int NROW                = 4;
    localparam int DEBOUNCE_FRAMES_DEF = 3;

    localparam int READY_BIT   = 31;
    localparam int OVERRUN_BIT = 30;
    localparam int HELD_BIT    = 29;

    typedef enum logic [1:0] {
        RELEASED   = 2'd0,
        PRESS_DB   = 2'd1,
        HELD       = 2'd2,
        RELEASE_DB = 2'd3
    } kp_state_t;

    // Returns {found, index} of the lowest-indexed pressed key (index = row*NCOL + col).
    function automatic logic [4:0] first_key(input logic [NROW*NCOL-1:0] keys);
        logic [4:0] result;
        result = '0;
        for (int i = NROW*NCOL-1; i >= 0; i--) begin
            if (keys[i]) begin
                result = {1'b1, 4'(i)};
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/keypad_debouncer.sv
// Frame-level debounce FSM: accepts a press/release after DEBOUNCE_FRAMES identical frames.
// latch is combinational on the accepting frame_valid cycle; state advances only on frame_valid.
module keypad_debouncer
    import keypad_scanner_pkg::*;
#(
    parameter int DEBOUNCE_FRAMES = DEBOUNCE_FRAMES_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_valid,
    input  logic       pressed,
    input  logic [3:0] code,
    output logic       latch,
    output logic [3:0] code_out,
    output logic       held
);

    localparam int CW = $clog2(DEBOUNCE_FRAMES + 1);

    kp_state_t      r_state;
    logic [CW-1:0]  r_count;
    logic [3:0]     r_cand;
    logic           r_held;

    logic [CW-1:0]  w_count_inc;
    logic           w_at_limit;
    logic           w_latch;

    assign w_count_inc = r_count + CW'(1);
    assign w_at_limit  = (w_count_inc >= CW'(DEBOUNCE_FRAMES));

    // A single-frame debounce accepts straight out of RELEASED.
    assign w_latch = frame_valid && pressed &&
                     ((r_state == PRESS_DB && code == r_cand && w_at_limit) ||
                      (r_state == RELEASED && DEBOUNCE_FRAMES <= 1));

    assign latch    = w_latch;
    assign code_out = code;
    assign held     = r_held;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= RELEASED;
            r_count <= '0;
            r_cand  <= '0;
            r_held  <= 1'b0;
        end else if (frame_valid) begin
            unique case (r_state)
                RELEASED: begin
                    if (pressed) begin
                        r_cand <= code;
                        if (w_latch) begin
                            r_state <= HELD;
                            r_count <= '0;
                            r_held  <= 1'b1;
                        end else begin
                            r_state <= PRESS_DB;
                            r_count <= CW'(1);
                        end
                    end
                end
                PRESS_DB: begin
                    if (!pressed) begin
                        r_state <= RELEASED;
                        r_count <= '0;
                    end else if (code != r_cand) begin
                        r_cand  <= code;
                        r_count <= CW'(1);
                    end else if (w_latch) begin
                        r_state <= HELD;
                        r_count <= '0;
                        r_held  <= 1'b1;
                    end else begin
                        r_count <= w_count_inc;
                    end
                end
                HELD: begin
                    // Any pressed frame keeps the key held; there is no auto-repeat.
                    if (!pressed) begin
                        if (DEBOUNCE_FRAMES <= 1) begin
                            r_state <= RELEASED;
                            r_count <= '0;
                            r_held  <= 1'b0;
                        end else begin
                            r_state <= RELEASE_DB;
                            r_count <= CW'(1);
                        end
                    end
                end
                RELEASE_DB: begin
                    if (pressed) begin
                        r_state <= HELD;
                        r_count <= '0;
                    end else if (w_at_limit) begin
                        r_state <= RELEASED;
                        r_count <= '0;
                        r_held  <= 1'b0;
                    end else begin
                        r_count <= w_count_inc;
                    end
                end
                default: begin
                    r_state <= RELEASED;
                    r_count <= '0;
                    r_held  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: column drive, row synchronizer, frame capture and CPU-visible status word.
// Ready/code appear one cycle after the accepting frame end; RE clears Ready/Overrun next cycle.
module keypad_scanner
    import keypad_scanner_pkg::*;
#(
    parameter int DEBOUNCE_FRAMES = DEBOUNCE_FRAMES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Call,
    input  logic        RE,
    input  logic [3:0]  rows,
    output logic [3:0]  colsel,
    output logic [31:0] DataOut,
    output logic        IRQ
);

    logic [3:0]            r_rows_meta;
    logic [3:0]            r_rows_sync;
    logic [1:0]            r_col;
    logic [3:0]            r_colsel;
    logic [NROW*NCOL-1:0]  r_keys;
    logic [3:0]            r_code;
    logic                  r_ready;
    logic                  r_overrun;

    logic [NROW*NCOL-1:0]  w_keys;
    logic                  w_frame_valid;
    logic [4:0]            w_first;
    logic                  w_latch;
    logic [3:0]            w_code_out;
    logic                  w_held;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rows_meta <= 4'hF;
            r_rows_sync <= 4'hF;
        end else begin
            r_rows_meta <= rows;
            r_rows_sync <= r_rows_meta;
        end
    end

    // Rows are active-low: a low row while this column is driven means that key is down.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_col    <= 2'd0;
            r_colsel <= 4'b1110;
            r_keys   <= '0;
        end else if (Call) begin
            for (int r = 0; r < NROW; r++) begin
                r_keys[r*NCOL + int'(r_col)] <= ~r_rows_sync[r];
            end
            r_col    <= r_col + 2'd1;
            r_colsel <= {r_colsel[2:0], r_colsel[3]};
        end
    end

    // The last column's samples are merged in directly so the frame is evaluated on its own Call.
    always_comb begin
        w_keys = r_keys;
        for (int r = 0; r < NROW; r++) begin
            w_keys[r*NCOL + NCOL - 1] = ~r_rows_sync[r];
        end
    end

    assign w_frame_valid = Call && (r_col == 2'(NCOL - 1));
    assign w_first       = first_key(w_keys);

    keypad_debouncer #(
        .DEBOUNCE_FRAMES (DEBOUNCE_FRAMES)
    ) u_debouncer (
        .clk         (clk),
        .reset       (reset),
        .frame_valid (w_frame_valid),
        .pressed     (w_first[4]),
        .code        (w_first[3:0]),
        .latch       (w_latch),
        .code_out    (w_code_out),
        .held        (w_held)
    );

    // Overrun only exists alongside Ready, so it is set exactly when an unread code is replaced.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_code    <= 4'd0;
            r_ready   <= 1'b0;
            r_overrun <= 1'b0;
        end else if (w_latch) begin
            r_code    <= w_code_out;
            r_ready   <= 1'b1;
            r_overrun <= r_ready && !RE;
        end else if (RE) begin
            r_ready   <= 1'b0;
            r_overrun <= 1'b0;
        end
    end

    always_comb begin
        DataOut              = '0;
        DataOut[READY_BIT]   = r_ready;
        DataOut[OVERRUN_BIT] = r_overrun;
        DataOut[HELD_BIT]    = w_held;
        DataOut[3:0]         = r_code;
    end

    assign colsel = r_colsel;
    assign IRQ    = r_ready;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: a behavioural key matrix drives rows from colsel.
// Call is pulsed every 4 cycles; outputs are sampled on the falling edge.
module tb_keypad_scanner;

    logic        clk;
    logic        reset;
    logic        Call;
    logic        RE;
    logic [3:0]  rows;
    logic [3:0]  colsel;
    logic [31:0] DataOut;
    logic        IRQ;

    logic [15:0] keys;
    int          n_checks;
    int          n_fail;

    keypad_scanner dut (
        .clk     (clk),
        .reset   (reset),
        .Call    (Call),
        .RE      (RE),
        .rows    (rows),
        .colsel  (colsel),
        .DataOut (DataOut),
        .IRQ     (IRQ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        rows = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[r*4 + c] && !colsel[c]) rows[r] = 1'b0;
            end
        end
    end

    task automatic tick();
        repeat (3) @(negedge clk);
        Call = 1'b1;
        @(negedge clk);
        Call = 1'b0;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n * 4; i++) tick();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic pulse_re(output logic [31:0] seen);
        @(negedge clk);
        RE = 1'b1;
        #1 seen = DataOut;
        @(negedge clk);
        RE = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (colsel !== 4'b1110) begin n_fail++; $display("FAIL reset_colsel: got %b want 1110", colsel); end
        n_checks++; if (DataOut !== 32'h0) begin n_fail++; $display("FAIL reset_dataout: got %h want 00000000", DataOut); end
        n_checks++; if (IRQ !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b want 0", IRQ); end
    endtask

    task automatic test_idle();
        logic [3:0] exp_cs [4];
        exp_cs = '{4'hD, 4'hB, 4'h7, 4'hE};
        keys = '0;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++; if (colsel !== exp_cs[i]) begin n_fail++; $display("FAIL idle_colsel%0d: got %h want %h", i, colsel, exp_cs[i]); end
        end
        for (int f = 0; f < 20; f++) begin
            frames(1);
            n_checks++; if (DataOut !== 32'h0) begin n_fail++; $display("FAIL idle_frame%0d: DataOut=%h want 00000000", f, DataOut); end
        end
    endtask

    task automatic test_press();
        logic [31:0] seen;
        keys = '0;
        keys[9] = 1'b1;
        frames(2);
        n_checks++; if (DataOut !== 32'h0) begin n_fail++; $display("FAIL press_2frames: DataOut=%h want 00000000", DataOut); end
        repeat (3) tick();
        n_checks++; if (IRQ !== 1'b0) begin n_fail++; $display("FAIL press_before_edge: IRQ=%b want 0", IRQ); end
        tick();
        n_checks++; if (DataOut !== 32'hA000_0009) begin n_fail++; $display("FAIL press_latch: DataOut=%h want a0000009", DataOut); end
        n_checks++; if (IRQ !== 1'b1) begin n_fail++; $display("FAIL press_irq: IRQ=%b want 1", IRQ); end
        repeat (10) @(negedge clk);
        n_checks++; if (colsel !== 4'b1110) begin n_fail++; $display("FAIL freeze_colsel: got %b want 1110", colsel); end
        pulse_re(seen);
        n_checks++; if (seen !== 32'hA000_0009) begin n_fail++; $display("FAIL read_preclear: saw %h want a0000009", seen); end
        n_checks++; if (DataOut !== 32'h2000_0009) begin n_fail++; $display("FAIL read_cleared: DataOut=%h want 20000009", DataOut); end
        frames(5);
        n_checks++; if (DataOut !== 32'h2000_0009) begin n_fail++; $display("FAIL no_repeat: DataOut=%h want 20000009", DataOut); end
        keys = '0;
        frames(1);
        n_checks++; if (DataOut !== 32'h2000_0009) begin n_fail++; $display("FAIL release_db_held: DataOut=%h want 20000009", DataOut); end
        frames(2);
        n_checks++; if (DataOut !== 32'h0000_0009) begin n_fail++; $display("FAIL released_keep_code: DataOut=%h want 00000009", DataOut); end
    endtask

    task automatic test_bounce();
        logic [31:0] seen;
        keys = '0;
        keys[9] = 1'b1;
        frames(2);
        keys = '0;
        frames(1);
        keys[9] = 1'b1;
        for (int f = 4; f <= 5; f++) begin
            frames(1);
            n_checks++; if (DataOut[31] !== 1'b0) begin n_fail++; $display("FAIL bounce_frame%0d: Ready=%b want 0", f, DataOut[31]); end
        end
        frames(1);
        n_checks++; if (DataOut !== 32'hA000_0009) begin n_fail++; $display("FAIL bounce_latch: DataOut=%h want a0000009", DataOut); end
        pulse_re(seen);
        keys = '0;
        frames(3);
    endtask

    task automatic test_overrun();
        logic [31:0] seen;
        keys = '0;
        keys[9] = 1'b1;
        frames(3);
        n_checks++; if (DataOut !== 32'hA000_0009) begin n_fail++; $display("FAIL ovr_first: DataOut=%h want a0000009", DataOut); end
        keys = '0;
        frames(3);
        n_checks++; if (DataOut !== 32'h8000_0009) begin n_fail++; $display("FAIL ovr_released: DataOut=%h want 80000009", DataOut); end
        keys[0] = 1'b1;
        frames(3);
        n_checks++; if (DataOut !== 32'hE000_0000) begin n_fail++; $display("FAIL ovr_set: DataOut=%h want e0000000", DataOut); end
        pulse_re(seen);
        n_checks++; if (DataOut !== 32'h2000_0000) begin n_fail++; $display("FAIL ovr_cleared: DataOut=%h want 20000000", DataOut); end
        keys = '0;
        frames(3);
    endtask

    task automatic test_re_on_latch();
        logic [31:0] seen;
        keys = '0;
        keys[9] = 1'b1;
        frames(3);
        keys = '0;
        frames(3);
        keys[5] = 1'b1;
        frames(2);
        repeat (3) tick();
        repeat (3) @(negedge clk);
        Call = 1'b1;
        RE   = 1'b1;
        #1 seen = DataOut;
        @(negedge clk);
        Call = 1'b0;
        RE   = 1'b0;
        n_checks++; if (seen !== 32'h8000_0009) begin n_fail++; $display("FAIL coincide_preclear: saw %h want 80000009", seen); end
        n_checks++; if (DataOut !== 32'hA000_0005) begin n_fail++; $display("FAIL coincide_result: DataOut=%h want a0000005", DataOut); end
        pulse_re(seen);
        keys = '0;
        frames(3);
    endtask

    task automatic test_multi_reset();
        logic [31:0] seen;
        keys = '0;
        keys[3]  = 1'b1;
        keys[12] = 1'b1;
        frames(3);
        n_checks++; if (DataOut !== 32'hA000_0003) begin n_fail++; $display("FAIL multi_code: DataOut=%h want a0000003", DataOut); end
        pulse_re(seen);
        keys = '0;
        frames(3);
        keys[3]  = 1'b1;
        keys[12] = 1'b1;
        frames(1);
        repeat (2) tick();
        do_reset();
        n_checks++; if (colsel !== 4'b1110) begin n_fail++; $display("FAIL midreset_colsel: got %b want 1110", colsel); end
        n_checks++; if (DataOut !== 32'h0) begin n_fail++; $display("FAIL midreset_dataout: got %h want 00000000", DataOut); end
        n_checks++; if (IRQ !== 1'b0) begin n_fail++; $display("FAIL midreset_irq: got %b want 0", IRQ); end
        frames(2);
        n_checks++; if (DataOut !== 32'h0) begin n_fail++; $display("FAIL postreset_nolatch: DataOut=%h want 00000000", DataOut); end
        frames(1);
        n_checks++; if (DataOut !== 32'hA000_0003) begin n_fail++; $display("FAIL postreset_latch: DataOut=%h want a0000003", DataOut); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        Call     = 1'b0;
        RE       = 1'b0;
        keys     = '0;
        test_reset();
        test_idle();
        test_press();
        test_bounce();
        test_overrun();
        test_re_on_latch();
        test_multi_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 SHALL provide parameter DEBOUNCE_FRAMES, default 3, number of identical consecutive scan frames required to accept a press or a release.
REQ-002 SHALL provide port clk  input  1  system clock; all logic on posedge.
REQ-003 SHALL provide port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL provide port Call  input  1  one-cycle scan-tick enable, same tick that advances the tube multiplexer.
REQ-005 SHALL provide port RE  input  1  CPU read strobe; one cycle per load from the keypad address.
REQ-006 SHALL provide port rows  input  4  keypad row lines, active-low, externally pulled up, asynchronous.
REQ-007 SHALL provide port colsel  output  4  column drive, active-low one-hot.
REQ-008 SHALL provide port DataOut  output  32  status/code word: [31] Ready, [30] Overrun, [29] Held, [28:4] zero, [3:0] key code.
REQ-009 SHALL provide port IRQ  output  1  equals Ready.

Function
REQ-010 SHALL pass rows through a two-flop synchronizer; all following logic uses the synchronized value only.
REQ-011 SHALL drive one column low at a time, starting with column 0 (colsel=4'b1110) and advancing 0->1->2->3->0 on each Call.
REQ-012 SHALL sample the synchronized rows on each Call for the column currently driven, then advance the column in the same cycle.
REQ-013 SHALL treat the four samples of columns 0..3 as one frame, evaluated on the Call that samples column 3.
REQ-014 SHALL encode the frame result as pressed or none; if pressed, code = row*4 + col of the lowest-indexed pressed key (column scanned first, then row); multiple keys resolve to that lowest index.
REQ-015 SHALL run a debounce FSM with states RELEASED, PRESS_DB, HELD, RELEASE_DB, updated only at frame end.
REQ-016 RELEASED: pressed frame -> PRESS_DB with count=1 and candidate=code; none -> stay.
REQ-017 PRESS_DB: pressed with the same code -> count+1; when count reaches DEBOUNCE_FRAMES, latch the code and go to HELD; a different code -> restart with count=1 on the new code; none -> RELEASED.
REQ-018 HELD: none -> RELEASE_DB with count=1; pressed (any code) -> stay; held-key auto-repeat SHALL NOT occur.
REQ-019 RELEASE_DB: none -> count+1; at DEBOUNCE_FRAMES -> RELEASED; pressed -> HELD.
REQ-020 Held bit SHALL be 1 in states HELD and RELEASE_DB, and 0 otherwise.
REQ-021 On latch: code register updated and Ready set in the next cycle; if Ready was already 1 and RE is not asserted that cycle, Overrun SHALL be set.
REQ-022 RE SHALL clear Ready and Overrun in the next cycle; DataOut is combinational from registers, so the CPU sees pre-clear values on the RE cycle.
REQ-023 If RE and latch coincide: Ready=1, Overrun=0, and the code is the new one.
REQ-024 DataOut[3:0] SHALL retain the last latched code after it is read.
REQ-025 Call held low SHALL freeze the column, frame, and FSM; RE SHALL still act.

Reset
REQ-026 The block SHALL return to the following values on reset: colsel=4'b1110, column index 0, synchronizer flops 4'b1111, FSM RELEASED, count 0, code 0, Ready/Overrun/Held 0, DataOut=0, IRQ=0.
REQ-027 Reset mid-frame or mid-debounce SHALL discard partial frame and count; no latch occurs from pre-reset samples.

Structure
REQ-028 The shared package SHALL hold NCOL=4, NROW=4, DEBOUNCE_FRAMES default, DataOut bit positions (READY_BIT=31, OVERRUN_BIT=30, HELD_BIT=29), and the FSM state encoding.
REQ-029 The FSM and count SHALL live in sub-module keypad_debouncer (frame_valid, pressed, code in; latch, code_out, held out); scanning, synchronizer, and CPU registers stay in the top level.

Verification
REQ-030 Reset then idle, Call every 4 cycles, rows=4'hF -> colsel cycles E,D,B,7; DataOut stays 0 for 20 frames.
REQ-031 Press row 2 / col 1 (rows=4'b1011 while colsel=4'b1101) for 3 frames -> Ready=1, DataOut=32'hA000_0009, IRQ=1 one cycle after the third frame end; RE -> DataOut=32'h2000_0009.
REQ-032 Bounce: key 9 pressed 2 frames, 1 none frame, then 3 frames -> exactly one latch, at the end of the 6th frame.
REQ-033 Latch key 9, no RE, release 3 frames, press key 0 for 3 frames -> DataOut=32'hE000_0000 (Overrun set); RE -> 32'h2000_0000.
REQ-034 RE asserted on the exact latch cycle of key 5 -> next cycle Ready=1, Overrun=0, code=5.
REQ-035 Keys 3 and 12 pressed together for 3 frames -> code=3; reset asserted during the 2nd frame -> no latch, all outputs at reset values.
